// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: transfer qualification, peripheral decode, address/data pipeline and ERROR response.
// Optional alignment checking is enabled by defining AHB_SLV_ALIGN_CHK_EN.
module ahb_slave_if #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter int          WIN_BITS  = 26
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic        valid,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        err_hready
);

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_state_t;

  localparam logic [2:0][31:0] SLV_BASE = {SLV2_BASE, SLV1_BASE, SLV0_BASE};

  err_state_t err_state_reg, err_state_next;
  logic       active;
  logic       in_range;
  logic       aligned;
  logic       legal;
  logic       illegal;

  // Window bases differ in their upper bits, so at most one select can match.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_decode
      assign tempselx[gi] = (haddr[31:WIN_BITS] == SLV_BASE[gi][31:WIN_BITS]);
    end
  endgenerate

`ifdef AHB_SLV_ALIGN_CHK_EN
  always_comb begin
    aligned = 1'b0;
    case (hsize)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~haddr[0];
      3'b010:  aligned = (haddr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end
`else
  logic unused_hsize;
  assign unused_hsize = ^hsize;
  assign aligned      = 1'b1;
`endif

  assign active   = hreadyin & htrans[1];
  assign in_range = |tempselx;
  assign legal    = active & in_range & aligned;
  assign illegal  = active & ~legal;

  assign valid  = hresetn & legal & (err_state_reg == ERR_IDLE);
  assign hrdata = prdata;

  // History is captured regardless of transfer type so the APB side sees a consistent view.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1    <= '0;
      haddr2    <= '0;
      hwdata1   <= '0;
      hwdata2   <= '0;
      hwritereg <= 1'b0;
    end else if (hreadyin) begin
      haddr1    <= haddr;
      haddr2    <= haddr1;
      hwdata1   <= hwdata;
      hwdata2   <= hwdata1;
      hwritereg <= hwrite;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_state_reg <= ERR_IDLE;
    end else begin
      err_state_reg <= err_state_next;
    end
  end

  always_comb begin
    err_state_next = ERR_IDLE;
    hresp          = 2'b00;
    err_hready     = 1'b1;
    case (err_state_reg)
      ERR_IDLE: err_state_next = illegal ? ERR_1 : ERR_IDLE;
      ERR_1: begin
        hresp          = 2'b01;
        err_hready     = 1'b0;
        err_state_next = ERR_2;
      end
      ERR_2: begin
        hresp          = 2'b01;
        err_state_next = illegal ? ERR_1 : ERR_IDLE;
      end
      default: err_state_next = ERR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if; each task covers one scenario with inline comparisons.
module tb_ahb_slave_if;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        valid;
  logic [31:0] haddr1;
  logic [31:0] haddr2;
  logic [31:0] hwdata1;
  logic [31:0] hwdata2;
  logic        hwritereg;
  logic [2:0]  tempselx;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        err_hready;

  int errors = 0;
  int checks = 0;

  ahb_slave_if dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hwrite     (hwrite),
    .hreadyin   (hreadyin),
    .htrans     (htrans),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .prdata     (prdata),
    .valid      (valid),
    .haddr1     (haddr1),
    .haddr2     (haddr2),
    .hwdata1    (hwdata1),
    .hwdata2    (hwdata2),
    .hwritereg  (hwritereg),
    .tempselx   (tempselx),
    .hrdata     (hrdata),
    .hresp      (hresp),
    .err_hready (err_hready)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    htrans   = t;
    hwrite   = w;
    hreadyin = r;
    haddr    = a;
    hwdata   = d;
    hsize    = s;
    #1;
    $display("txn t=%0t htrans=%b hwrite=%b hready=%b haddr=%h hwdata=%h hsize=%b",
             $time, t, w, r, a, d, s);
  endtask

  task automatic test_reset();
    drive(2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 3'b010);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid_hold: got %b want 0", valid); end
    tick();
    checks++; if (haddr1 !== 32'h0) begin errors++; $display("FAIL rst_haddr1: got %h want 0", haddr1); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL rst_hresp: got %b want 00", hresp); end
    checks++; if (err_hready !== 1'b1) begin errors++; $display("FAIL rst_err_hready: got %b want 1", err_hready); end
    #2 hresetn = 1'b1;
    // traffic then error, then reset asserted mid-cycle
    drive(2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'hA5A5_A5A5, 3'b010);
    tick();
    checks++; if (hresp !== 2'b01) begin errors++; $display("FAIL rst_pre_err: got %b want 01", hresp); end
    drive(2'b10, 1'b1, 1'b1, 32'h8000_0004, 32'h5A5A_5A5A, 3'b010);
    tick();
    checks++; if (haddr2 !== 32'h9000_0000) begin errors++; $display("FAIL rst_pre_haddr2: got %h want 90000000", haddr2); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if (haddr1 !== 32'h0 || haddr2 !== 32'h0) begin errors++; $display("FAIL rst_async_haddr: got %h/%h want 0/0", haddr1, haddr2); end
    checks++; if (hwdata1 !== 32'h0 || hwdata2 !== 32'h0) begin errors++; $display("FAIL rst_async_hwdata: got %h/%h want 0/0", hwdata1, hwdata2); end
    checks++; if (hwritereg !== 1'b0) begin errors++; $display("FAIL rst_async_hwritereg: got %b want 0", hwritereg); end
    checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin errors++; $display("FAIL rst_async_resp: got %b/%b want 00/1", hresp, err_hready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", valid); end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    tick();
    #2 hresetn = 1'b1;
  endtask

  task automatic test_write();
    tick();
    drive(2'b10, 1'b1, 1'b1, 32'h8400_0010, 32'h1111_1111, 3'b010);
    checks++; if (tempselx !== 3'b010) begin errors++; $display("FAIL wr0_sel: got %b want 010", tempselx); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wr0_valid: got %b want 1", valid); end
    tick();
    checks++; if (haddr1 !== 32'h8400_0010) begin errors++; $display("FAIL wr0_haddr1: got %h want 84000010", haddr1); end
    checks++; if (hwritereg !== 1'b1) begin errors++; $display("FAIL wr0_hwritereg: got %b want 1", hwritereg); end
    drive(2'b11, 1'b1, 1'b1, 32'h8400_0014, 32'hDEAD_BEEF, 3'b010);
    checks++; if (tempselx !== 3'b010 || valid !== 1'b1) begin errors++; $display("FAIL wr1_sel_valid: got %b/%b want 010/1", tempselx, valid); end
    tick();
    checks++; if (haddr2 !== 32'h8400_0010) begin errors++; $display("FAIL wr1_haddr2: got %h want 84000010", haddr2); end
    checks++; if (haddr1 !== 32'h8400_0014) begin errors++; $display("FAIL wr1_haddr1: got %h want 84000014", haddr1); end
    checks++; if (hwdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr1_hwdata1: got %h want deadbeef", hwdata1); end
    checks++; if (hwdata2 !== 32'h1111_1111) begin errors++; $display("FAIL wr1_hwdata2: got %h want 11111111", hwdata2); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b0, 1'b0, 32'h8000_0100 + 32'(i * 4), 32'h0000_F000 + 32'(i), 3'b010);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_valid%0d: got %b want 0", i, valid); end
      tick();
      checks++; if (haddr1 !== 32'h8400_0014 || haddr2 !== 32'h8400_0010) begin errors++; $display("FAIL hold_haddr%0d: got %h/%h want 84000014/84000010", i, haddr1, haddr2); end
      checks++; if (hwdata1 !== 32'hDEAD_BEEF || hwdata2 !== 32'h1111_1111) begin errors++; $display("FAIL hold_hwdata%0d: got %h/%h want deadbeef/11111111", i, hwdata1, hwdata2); end
      checks++; if (hwritereg !== 1'b1) begin errors++; $display("FAIL hold_hwritereg%0d: got %b want 1", i, hwritereg); end
    end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL hold_hresp: got %b want 00", hresp); end
  endtask

  task automatic test_decode();
    drive(2'b01, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 3'b010);
    checks++; if (valid !== 1'b0 || tempselx !== 3'b001) begin errors++; $display("FAIL dec_busy: got %b/%b want 0/001", valid, tempselx); end
    drive(2'b00, 1'b0, 1'b1, 32'h8400_0000, 32'h0, 3'b010);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dec_idle: got %b want 0", valid); end
    drive(2'b10, 1'b0, 1'b1, 32'h83FF_FFFC, 32'h0, 3'b010);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b001) begin errors++; $display("FAIL dec_top0: got %b/%b want 1/001", valid, tempselx); end
    drive(2'b10, 1'b0, 1'b1, 32'h8BFF_FFFC, 32'h0, 3'b010);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errors++; $display("FAIL dec_top2: got %b/%b want 1/100", valid, tempselx); end
    tick();
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL dec_hresp: got %b want 00", hresp); end
  endtask

  task automatic test_out_of_range();
    drive(2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 3'b010);
    checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin errors++; $display("FAIL oor_addr: got %b/%b want 0/000", valid, tempselx); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin errors++; $display("FAIL oor_err1: got %b/%b want 01/0", hresp, err_hready); end
    tick();
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b1) begin errors++; $display("FAIL oor_err2: got %b/%b want 01/1", hresp, err_hready); end
    tick();
    checks++; if (hresp !== 2'b00 || err_hready !== 1'b1) begin errors++; $display("FAIL oor_okay: got %b/%b want 00/1", hresp, err_hready); end
  endtask

  task automatic test_error_recovery();
    drive(2'b10, 1'b0, 1'b1, 32'h9000_0000, 32'h0, 3'b010);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    tick();
    prdata = 32'h1234_5678;
    drive(2'b10, 1'b0, 1'b1, 32'h8800_0000, 32'h0, 3'b010);
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b1) begin errors++; $display("FAIL rec_in_err2: got %b/%b want 01/1", hresp, err_hready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rec_valid_err2: got %b want 0", valid); end
    checks++; if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL rec_hrdata: got %h want 12345678", hrdata); end
    tick();
    checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errors++; $display("FAIL rec_valid_idle: got %b/%b want 1/100", valid, tempselx); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL rec_hresp: got %b want 00", hresp); end
    prdata = 32'hCAFE_F00D;
    #1;
    checks++; if (hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rec_hrdata2: got %h want cafef00d", hrdata); end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 3'b010);
    tick();
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin errors++; $display("FAIL b2b_err1a: got %b/%b want 01/0", hresp, err_hready); end
    tick();
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL b2b_err2a: got %b/%b/%b want 01/1/0", hresp, err_hready, valid); end
    tick();
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin errors++; $display("FAIL b2b_err1b: got %b/%b want 01/0", hresp, err_hready); end
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    tick();
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b1) begin errors++; $display("FAIL b2b_err2b: got %b/%b want 01/1", hresp, err_hready); end
    tick();
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL b2b_okay: got %b want 00", hresp); end
  endtask

  task automatic test_align();
    drive(2'b10, 1'b0, 1'b1, 32'h8000_0002, 32'h0, 3'b010);
    checks++; if (tempselx !== 3'b001) begin errors++; $display("FAIL aln_sel: got %b want 001", tempselx); end
`ifdef AHB_SLV_ALIGN_CHK_EN
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL aln_valid: got %b want 0", valid); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    checks++; if (hresp !== 2'b01 || err_hready !== 1'b0) begin errors++; $display("FAIL aln_err1: got %b/%b want 01/0", hresp, err_hready); end
`else
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL aln_valid: got %b want 1", valid); end
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b010);
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL aln_okay: got %b want 00", hresp); end
`endif
    tick();
    tick();
  endtask

  initial begin
    hresetn  = 1'b0;
    hwrite   = 1'b0;
    hreadyin = 1'b1;
    htrans   = 2'b00;
    hsize    = 3'b010;
    haddr    = 32'h0;
    hwdata   = 32'h0;
    prdata   = 32'h0;
    test_reset();
    test_write();
    test_hold();
    test_decode();
    test_out_of_range();
    test_error_recovery();
    test_back_to_back();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
